adder_issue_ctrl: RTL and testbench

- Upstream issue stage for the dynamic 32-bit ripple adder.
- Accepts operand requests over a valid/ready handshake, then drives and holds the adder's a/b/cin inputs.
- Controls the adder's start signal F and predicts completion time from the middle propagate bits, using the same short/long rule as the adder's timer.
- Captures sum/cout into a one-deep output register with its own valid/ready handshake. One operation is in flight at a time.

---
 rtl/adder_issue_ctrl.sv | 112 +++++++++++
 tb/tb_adder_issue_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_issue_ctrl.sv
// Issue stage for the dynamic ripple adder: accepts operands, drives/holds the adder,
// times completion from the middle propagate window and captures the result.
module adder_issue_ctrl #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned PSTART    = 14,
  parameter int unsigned PWIDTH    = 4,
  parameter int unsigned SHORT_CYC = 7,
  parameter int unsigned LONG_CYC  = 15,
  parameter int unsigned STAT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic              in_cin,
  output logic [WIDTH-1:0]  add_a,
  output logic [WIDTH-1:0]  add_b,
  output logic              add_cin,
  output logic              add_F,
  input  logic [WIDTH-1:0]  add_sum,
  input  logic              add_cout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_sum,
  output logic              out_cout,
  output logic              out_long,
  output logic              busy,
  output logic [STAT_W-1:0] long_cnt
);

  localparam int unsigned CNT_W = $clog2(LONG_CYC + 1);

  if (SHORT_CYC < 1 || SHORT_CYC > LONG_CYC || PSTART + PWIDTH > WIDTH) begin : g_bad_params
    $error("adder_issue_ctrl: illegal parameter combination");
  end

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last_cnt;
  logic             is_long_q;
  logic             is_long_in;
  logic             accept;
  logic             done;

  // Full propagate across the middle window forces the worst-case carry chain.
  assign is_long_in = &(in_a[PSTART +: PWIDTH] ^ in_b[PSTART +: PWIDTH]);
  assign last_cnt   = is_long_q ? CNT_W'(LONG_CYC - 1) : CNT_W'(SHORT_CYC - 1);
  assign accept     = in_valid && in_ready;
  assign done       = (state == WAIT) && (cnt == last_cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (done)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE) && (!out_valid || out_ready);
    add_F    = (state != WAIT);
    busy     = (state == WAIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      add_a     <= '0;
      add_b     <= '0;
      add_cin   <= 1'b0;
      is_long_q <= 1'b0;
      cnt       <= '0;
      long_cnt  <= '0;
    end else if (accept) begin
      add_a     <= in_a;
      add_b     <= in_b;
      add_cin   <= in_cin;
      is_long_q <= is_long_in;
      cnt       <= '0;
      if (is_long_in && long_cnt != '1) long_cnt <= long_cnt + 1'b1;
    end else if (state == WAIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  // A capture on the same edge as a consume keeps out_valid high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_long  <= 1'b0;
    end else if (done) begin
      out_valid <= 1'b1;
      out_sum   <= add_sum;
      out_cout  <= add_cout;
      out_long  <= is_long_q;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_issue_ctrl.sv
// Randomized bench for adder_issue_ctrl against a cycle-count reference model.
module tb_adder_issue_ctrl;

  localparam int unsigned SW     = 4;
  localparam int          SHORTK = 7;
  localparam int          LONGK  = 15;
  localparam int          LMAX   = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_a = '0;
  logic [31:0]   in_b = '0;
  logic          in_cin = 1'b0;
  logic [31:0]   add_a, add_b, add_sum;
  logic          add_cin, add_F, add_cout;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_sum;
  logic          out_cout, out_long, busy;
  logic [SW-1:0] long_cnt;

  always #5 clk = ~clk;

  // Ideal adder standing in for the ripple adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_cin};

  adder_issue_ctrl #(.STAT_W(SW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_F(add_F),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_long(out_long), .busy(busy), .long_cnt(long_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: one op in flight, completing a fixed number of edges after accept.
  int          cyc = 0;
  bit          m_busy, m_rv, m_cout, m_long, m_cin, m_op_long, m_op_cout, last_acc;
  int          m_done_at, m_lcnt, last_acc_cyc;
  logic [31:0] m_sum, m_a, m_b, m_op_sum;

  function automatic bit window_long(input logic [31:0] a, input logic [31:0] b);
    return (((a ^ b) >> 14) & 32'hF) == 32'hF;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_rv = 0; m_cout = 0; m_long = 0; m_cin = 0;
    m_sum = '0; m_a = '0; m_b = '0; m_lcnt = 0; last_acc = 0;
  endtask

  task automatic check_outputs(input bit exp_ready);
    chk("in_ready",  64'(in_ready),  64'(exp_ready));
    chk("busy",      64'(busy),      64'(m_busy));
    chk("add_F",     64'(add_F),     64'(!m_busy));
    chk("out_valid", 64'(out_valid), 64'(m_rv));
    chk("out_sum",   64'(out_sum),   64'(m_sum));
    chk("out_cout",  64'(out_cout),  64'(m_cout));
    chk("out_long",  64'(out_long),  64'(m_long));
    chk("long_cnt",  64'(long_cnt),  64'(m_lcnt));
    chk("add_a",     64'(add_a),     64'(m_a));
    chk("add_b",     64'(add_b),     64'(m_b));
    chk("add_cin",   64'(add_cin),   64'(m_cin));
  endtask

  task automatic step(input bit iv, input logic [31:0] a, input logic [31:0] b,
                      input bit ci, input bit ordy);
    bit          exp_ready, acc, lng;
    logic [32:0] s;
    @(negedge clk);
    in_valid = iv; in_a = a; in_b = b; in_cin = ci; out_ready = ordy;
    #1;
    exp_ready = !m_busy && (!m_rv || ordy);
    check_outputs(exp_ready);
    @(posedge clk);
    cyc++;
    acc = iv && exp_ready;
    if (m_busy && cyc == m_done_at) begin
      m_rv = 1; m_sum = m_op_sum; m_cout = m_op_cout; m_long = m_op_long; m_busy = 0;
    end else if (m_rv && ordy) begin
      m_rv = 0;
    end
    if (acc) begin
      lng = window_long(a, b);
      s = {1'b0, a} + {1'b0, b} + 33'(ci);
      m_busy = 1; m_a = a; m_b = b; m_cin = ci;
      m_op_long = lng; m_op_sum = s[31:0]; m_op_cout = s[32];
      m_done_at = cyc + (lng ? LONGK : SHORTK);
      if (lng && m_lcnt < LMAX) m_lcnt++;
      last_acc_cyc = cyc;
    end
    last_acc = acc;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit ci);
    for (int i = 0; i < 40; i++) begin
      step(1, a, b, ci, 1);
      if (last_acc) break;
    end
    if (!last_acc) chk("issue_timeout", 64'(0), 64'(1));
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, ordy);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (m_busy || m_rv); i++) step(0, '0, '0, 0, 1);
    chk("drain", 64'(m_busy || m_rv), 64'(0));
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc_c[3];
    bit          iv, ci, ordy, hold;
    logic [31:0] a, b;
    model_reset();
    #12;
    check_outputs(1'b1);
    @(negedge clk);
    reset = 1'b0;

    issue(32'h0000_0005, 32'h0000_0003, 0);   // short path
    drain();
    issue(32'h0003_C000, 32'h0000_0000, 0);   // long path
    drain();
    issue(32'hFFFF_FFFF, 32'h0000_0000, 1);   // carry wrap, long
    drain();
    chk("wrap_sum",  64'(out_sum),  64'(0));
    chk("wrap_cout", 64'(out_cout), 64'(1));

    // Backpressure, then consume and accept on one edge
    issue(32'h0000_0005, 32'h0000_0003, 0);
    idle(10, 0);
    for (int i = 0; i < 5; i++) step(1, 32'h0000_0100, 32'h0000_0023, 1, 0);
    step(1, 32'h0000_0100, 32'h0000_0023, 1, 1);
    chk("bp_same_edge_accept", 64'(last_acc), 64'(1));
    drain();

    // Back-to-back short ops
    for (int i = 0; i < 3; i++) begin
      issue(32'(i + 1), 32'(i * 3), 0);
      acc_c[i] = last_acc_cyc;
    end
    chk("b2b_gap0", 64'(acc_c[1] - acc_c[0]), 64'(8));
    chk("b2b_gap1", 64'(acc_c[2] - acc_c[1]), 64'(8));
    drain();

    // Reset in the middle of a long op
    issue(32'h0003_C000, 32'h0000_0001, 0);
    idle(4, 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs(1'b1);
    @(negedge clk);
    reset = 1'b0;
    idle(25, 0);

    // Random traffic
    hold = 0; iv = 0; a = '0; b = '0; ci = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!hold) begin
        iv = ($urandom % 3) != 0;
        ci = 1'($urandom % 2);
        case ($urandom % 4)
          0: begin a = $urandom; b = $urandom; end
          1: begin b = $urandom; a = b ^ 32'h0003_C000 ^ ($urandom & 32'hFFFC_3FFF); end
          2: begin a = $urandom % 256; b = $urandom % 256; end
          default: begin a = 32'hFFFF_FFFF; b = $urandom % 2; end
        endcase
      end
      ordy = ($urandom % 4) != 0;
      step(iv, a, b, ci, ordy);
      hold = iv && !last_acc;
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
